fe_ibuf: RTL

- Instruction buffer between the fetch return path (FE0) and the decode stage (FE1 → DE0).
- Captures fetched instruction packets and presents the oldest one to decode as valid_fe1/instr_fe1.
- Holds the head stable while decode stalls.
- Flushes all contents on a branch mispredict from retire.
- Provides an almost-full indication so fetch can throttle, with SKID in-flight slots of slack.

---
 rtl/fe_ibuf_pkg.sv | 23 ++
 rtl/fe_ibuf_if.sv | 41 ++++
 rtl/fe_ibuf.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fe_ibuf_pkg.sv
// -----------------------------------------------------------------------------
// fe_ibuf_pkg
//   Shared front-end definitions. Fetch and the top level both size their
//   throttling from IBUF_DEPTH / IBUF_SKID so they can never disagree on how
//   many in-flight returns the instruction buffer has to absorb.
//
//   t_instr_pkt : one fetched instruction packet (instr, pc, and a simulation
//                 sequence id when SIMULATION is defined).
// -----------------------------------------------------------------------------
package fe_ibuf_pkg;

    localparam int IBUF_DEPTH = 4;  // buffered packets, power of two, >= 2
    localparam int IBUF_SKID  = 1;  // fetch request-to-return latency in cycles

    typedef struct packed {
`ifdef SIMULATION
        logic [31:0] simid;
`endif
        logic [31:0] pc;
        logic [31:0] instr;
    } t_instr_pkt;

endpackage : fe_ibuf_pkg

// File: rtl/fe_ibuf_if.sv
// -----------------------------------------------------------------------------
// fe_ibuf_if
//   Bundle between fetch/decode (master) and the instruction buffer (slave).
//
//   valid_fe0, instr_fe0 : packet returned by fetch this cycle
//   stall                : decode cannot accept the head packet
//   br_mispred_rb1       : flush request from retire
//   ibuf_afull_fe0       : occupancy >= DEPTH-SKID, fetch must stop issuing
//   ibuf_full_fe0        : occupancy == DEPTH
//   valid_fe1, instr_fe1 : head packet toward decode
//   occ_fe1              : current occupancy (perf/debug)
// -----------------------------------------------------------------------------
interface fe_ibuf_if
    import fe_ibuf_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH
) ();

    localparam int CNTW = $clog2(DEPTH + 1);

    logic            valid_fe0;
    t_instr_pkt      instr_fe0;
    logic            stall;
    logic            br_mispred_rb1;
    logic            ibuf_afull_fe0;
    logic            ibuf_full_fe0;
    logic            valid_fe1;
    t_instr_pkt      instr_fe1;
    logic [CNTW-1:0] occ_fe1;

    modport master (
        output valid_fe0, instr_fe0, stall, br_mispred_rb1,
        input  ibuf_afull_fe0, ibuf_full_fe0, valid_fe1, instr_fe1, occ_fe1
    );

    modport slave (
        input  valid_fe0, instr_fe0, stall, br_mispred_rb1,
        output ibuf_afull_fe0, ibuf_full_fe0, valid_fe1, instr_fe1, occ_fe1
    );

endinterface : fe_ibuf_if

// File: rtl/fe_ibuf.sv
// -----------------------------------------------------------------------------
// fe_ibuf
//   Instruction buffer between the fetch return path (FE0) and decode (FE1).
//   Captures fetched packets in a DEPTH-entry circular array and presents the
//   oldest one to decode. The head holds while decode stalls, a branch
//   mispredict from retire flushes everything, and an almost-full flag leaves
//   SKID slots for packets fetch already has in flight.
//
//   clk     : core clock
//   reset_n : asynchronous, active-low reset
//   ibuf    : fe_ibuf_if.slave bundle (see fe_ibuf_if.sv)
// -----------------------------------------------------------------------------
module fe_ibuf
    import fe_ibuf_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH,
    parameter int SKID  = IBUF_SKID
) (
    input  logic     clk,
    input  logic     reset_n,
    fe_ibuf_if.slave ibuf
);

    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int PTRW = $clog2(DEPTH);

    t_instr_pkt      entry_q [DEPTH];
    logic [PTRW-1:0] rd_ptr_q;
    logic [PTRW-1:0] wr_ptr_q;
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    logic flush;
    logic nonempty;
    logic full;
    logic afull;
    logic enq;
    logic deq;

    // Full and empty come from count, never from pointer equality, since the
    // pointers coincide in both cases after a wrap.
    always_comb begin
        // NOTE: every signal written here gets a value up front, so no path can
        // leave one unassigned and infer a latch.
        flush    = ibuf.br_mispred_rb1;
        nonempty = (count_q != '0);
        full     = (count_q == CNTW'(DEPTH));
        afull    = (count_q >= CNTW'(DEPTH - SKID));
        // Full blocks the write even when the head leaves this same cycle:
        // there is no pass-through path.
        enq      = ibuf.valid_fe0 & ~full & ~flush;
        deq      = nonempty & ~flush & ~ibuf.stall;
        count_d  = count_q + CNTW'(enq) - CNTW'(deq);
        if (flush) begin
            count_d = '0;
        end
    end

    assign ibuf.ibuf_afull_fe0 = afull;
    assign ibuf.ibuf_full_fe0  = full;
    assign ibuf.valid_fe1      = nonempty & ~flush;
    assign ibuf.occ_fe1        = count_q;
    // Head comes straight from the flops; zero while empty keeps stale data
    // off the decode bus.
    assign ibuf.instr_fe1      = nonempty ? entry_q[rd_ptr_q] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state uses <= so every flop samples pre-edge values no matter
        // how the statements are ordered.
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + PTRW'(1);
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is cleared on reset as well; it is only a few
    // entries, and it keeps X out of simulation and equivalence checking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (enq) begin
            entry_q[wr_ptr_q] <= ibuf.instr_fe0;
        end
    end

`ifdef ASSERT
    // Decode relies on the head staying put while it stalls.
    chk_no_change: assert property (@(posedge clk) disable iff (!reset_n)
        (ibuf.stall && ibuf.valid_fe1) |=> $stable(ibuf.instr_fe1));

    chk_count_range: assert property (@(posedge clk) disable iff (!reset_n)
        count_q <= CNTW'(DEPTH));

    // Fetch honouring afull never delivers into a full buffer.
    chk_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(ibuf.valid_fe0 && full));
`endif

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (reset_n && enq) begin
            $display("INFO fe_ibuf enq pc=%h simid=%0d", ibuf.instr_fe0.pc, ibuf.instr_fe0.simid);
        end
        if (reset_n && deq) begin
            $display("INFO fe_ibuf deq pc=%h simid=%0d", ibuf.instr_fe1.pc, ibuf.instr_fe1.simid);
        end
    end
`endif

endmodule : fe_ibuf
